// File: rtl/params_pkg.sv
// Shared Sv32 walker types and constants.
// CSR address constants live in csr_regfile, not here.
package params_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDR_WIDTH    = 32;

  localparam int SATP_MODE_BIT = 31;

  localparam int PTE_V         = 0;
  localparam int PTE_R         = 1;
  localparam int PTE_W         = 2;
  localparam int PTE_X         = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_REQ,
    S_L1_WAIT,
    S_L0_REQ,
    S_L0_WAIT,
    S_DONE
  } ptw_state_e;

endpackage

// File: rtl/page_table_walker.sv
// Sv32 two-level page table walker with bare-mode bypass.
// Define PTW_SUPERPAGE_EN to accept 4 MiB L1 leaves.
module page_table_walker #(
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] satp_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_vaddr_i,
  input  logic                  req_store_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [ADDR_WIDTH-1:0] resp_paddr_o,
  output logic                  resp_fault_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_resp_data_i
);
  import params_pkg::*;

  ptw_state_e            r_state;
  ptw_state_e            w_next;

  logic [ADDR_WIDTH-1:0] r_vaddr;
  logic                  r_store;
  logic [DATA_WIDTH-1:0] r_satp;
  logic [ADDR_WIDTH-1:0] r_l0_addr;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic                  r_fault;

  logic                  w_bare;
  logic [21:0]           w_ppn;
  logic                  w_v;
  logic                  w_r;
  logic                  w_w;
  logic                  w_x;
  logic                  w_invalid;
  logic                  w_leaf;
  logic                  w_wfault;
  logic [33:0]           w_l1_full;
  logic [33:0]           w_l0_full;
  logic [ADDR_WIDTH-1:0] w_l1_addr;
  logic [ADDR_WIDTH-1:0] w_l0_addr;
  logic                  w_l1_go_l0;
  logic                  w_l1_fault;
  logic [ADDR_WIDTH-1:0] w_l1_paddr;
  logic                  w_l0_fault;
  logic [ADDR_WIDTH-1:0] w_l0_paddr;
  logic                  w_unused;

  assign w_bare     = ~satp_i[SATP_MODE_BIT];

  assign w_ppn      = mem_resp_data_i[31:10];
  assign w_v        = mem_resp_data_i[PTE_V];
  assign w_r        = mem_resp_data_i[PTE_R];
  assign w_w        = mem_resp_data_i[PTE_W];
  assign w_x        = mem_resp_data_i[PTE_X];
  assign w_invalid  = ~w_v | (~w_r & w_w);
  assign w_leaf     = w_r | w_x;
  assign w_wfault   = r_store & ~w_w;

  assign w_l1_full  = {r_satp[21:0], 12'h000}
                    + {22'h0, r_vaddr[31:22], 2'b00};
  assign w_l0_full  = {w_ppn, 12'h000}
                    + {22'h0, r_vaddr[21:12], 2'b00};
  assign w_l1_addr  = w_l1_full[ADDR_WIDTH-1:0];
  assign w_l0_addr  = w_l0_full[ADDR_WIDTH-1:0];

  assign w_l1_go_l0 = ~w_invalid & ~w_leaf;

`ifdef PTW_SUPERPAGE_EN
  assign w_l1_fault = w_invalid
                    | (w_leaf & ((w_ppn[9:0] != 10'h0) | w_wfault));
  assign w_l1_paddr = ADDR_WIDTH'({w_ppn[19:10], r_vaddr[21:0]});
`else
  assign w_l1_fault = w_invalid | w_leaf;
  assign w_l1_paddr = '0;
`endif

  assign w_l0_fault = w_invalid | ~w_leaf | w_wfault;
  assign w_l0_paddr = ADDR_WIDTH'({w_ppn[19:0], r_vaddr[11:0]});

  // Bits that do not steer the walk: PTE A/D/G/U, upper satp.
  assign w_unused   = ^{r_satp[31:22], mem_resp_data_i[9:4],
                        w_l1_full[33:32], w_l0_full[33:32]};

  // State register; reset abandons any walk in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (req_valid_i)
                   w_next = w_bare ? S_DONE : S_L1_REQ;
      S_L1_REQ:  if (mem_req_ready_i) w_next = S_L1_WAIT;
      S_L1_WAIT: if (mem_resp_valid_i)
                   w_next = w_l1_go_l0 ? S_L0_REQ : S_DONE;
      S_L0_REQ:  if (mem_req_ready_i) w_next = S_L0_WAIT;
      S_L0_WAIT: if (mem_resp_valid_i) w_next = S_DONE;
      S_DONE:    if (resp_ready_i) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Moore outputs; addresses and results are zero outside their states.
  always_comb begin
    req_ready_o     = 1'b0;
    resp_valid_o    = 1'b0;
    resp_paddr_o    = '0;
    resp_fault_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    unique case (r_state)
      S_IDLE:   req_ready_o = 1'b1;
      S_L1_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = w_l1_addr;
      end
      S_L0_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = r_l0_addr;
      end
      S_DONE:   begin
        resp_valid_o = 1'b1;
        resp_paddr_o = r_paddr;
        resp_fault_o = r_fault;
      end
      default:  ;
    endcase
  end

  // Latch the request and fold each PTE into the walk result.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_vaddr   <= '0;
      r_store   <= 1'b0;
      r_satp    <= '0;
      r_l0_addr <= '0;
      r_paddr   <= '0;
      r_fault   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (req_valid_i) begin
          r_vaddr <= req_vaddr_i;
          r_store <= req_store_i;
          r_satp  <= satp_i;
          r_paddr <= req_vaddr_i;
          r_fault <= 1'b0;
        end
        S_L1_WAIT: if (mem_resp_valid_i) begin
          r_l0_addr <= w_l0_addr;
          r_fault   <= w_l1_fault;
          r_paddr   <= w_l1_fault ? '0 : w_l1_paddr;
        end
        S_L0_WAIT: if (mem_resp_valid_i) begin
          r_fault <= w_l0_fault;
          r_paddr <= w_l0_fault ? '0 : w_l0_paddr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_page_table_walker.sv
// Directed bench for page_table_walker.
// Superpage expectations follow PTW_SUPERPAGE_EN.
module tb_page_table_walker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] satp;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_vaddr;
  logic        req_store;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_paddr;
  logic        resp_fault;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  page_table_walker dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .satp_i           (satp),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_vaddr_i      (req_vaddr),
    .req_store_i      (req_store),
    .resp_valid_o     (resp_valid),
    .resp_ready_i     (resp_ready),
    .resp_paddr_o     (resp_paddr),
    .resp_fault_o     (resp_fault),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_req_addr_o   (mem_req_addr),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_data_i  (mem_resp_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ":rdy"},   32'(req_ready),     32'd1);
    chk({tag, ":rv"},    32'(resp_valid),    32'd0);
    chk({tag, ":flt"},   32'(resp_fault),    32'd0);
    chk({tag, ":pa"},    resp_paddr,         32'd0);
    chk({tag, ":mv"},    32'(mem_req_valid), 32'd0);
    chk({tag, ":ma"},    mem_req_addr,       32'd0);
  endtask

  task automatic walk(input string tag,
                      input logic [31:0] s, va,
                      input logic st,
                      input logic [31:0] pte0, pte1, a0, a1,
                      input int exp_reads,
                      input logic [31:0] exp_pa,
                      input logic exp_f,
                      input int exp_lat, stall, hold);
    int lat, reads, stl;
    logic pend;
    logic [31:0] pdata;
    bit done;
    @(negedge clk);
    satp = s; req_vaddr = va; req_store = st; req_valid = 1'b1;
    chk({tag, ":accept"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    satp = ~s; req_vaddr = ~va; req_store = ~st;
    lat = 0; reads = 0; stl = stall; pend = 1'b0;
    pdata = '0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      lat++;
      mem_resp_valid = pend;
      mem_resp_data  = pend ? pdata : 32'hDEAD_BEEF;
      pend = 1'b0;
      mem_req_ready = 1'b0;
      if (resp_valid) done = 1'b1;
      else if (mem_req_valid) begin
        chk({tag, ":maddr"}, mem_req_addr, reads == 0 ? a0 : a1);
        if (stl > 0) stl--;
        else begin
          mem_req_ready = 1'b1;
          pend = 1'b1;
          pdata = reads == 0 ? pte0 : pte1;
          reads++;
        end
      end
    end
    chk({tag, ":timeout"}, 32'(done), 32'd1);
    if (done) begin
      chk({tag, ":lat"},   32'(lat),       32'(exp_lat));
      chk({tag, ":reads"}, 32'(reads),     32'(exp_reads));
      chk({tag, ":pa"},    resp_paddr,     exp_pa);
      chk({tag, ":flt"},   32'(resp_fault), 32'(exp_f));
      chk({tag, ":busy"},  32'(req_ready), 32'd0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({tag, ":hold_v"},  32'(resp_valid), 32'd1);
        chk({tag, ":hold_pa"}, resp_paddr,      exp_pa);
      end
      resp_ready = 1'b1;
      satp = 32'h0; req_valid = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk({tag, ":no_accept"}, 32'(resp_valid), 32'd0);
      chk({tag, ":idle"},      32'(req_ready),  32'd1);
    end
  endtask

  logic [31:0] sp_pa;
  logic        sp_f;

  initial begin
`ifdef PTW_SUPERPAGE_EN
    sp_pa = 32'h8012_3456; sp_f = 1'b0;
`else
    sp_pa = 32'h0;         sp_f = 1'b1;
`endif
    rst_n = 1'b0; satp = '0; req_valid = 1'b0;
    req_vaddr = '0; req_store = 1'b0; resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

    walk("bare", 32'h0, 32'h1234_5678, 1'b0, 0, 0, 0, 0,
         0, 32'h1234_5678, 1'b0, 1, 0, 0);
    walk("bare_ppn", 32'h0000_0010, 32'hCAFE_0123, 1'b1, 0, 0, 0, 0,
         0, 32'hCAFE_0123, 1'b0, 1, 0, 1);
    walk("two_lvl", 32'h8000_0010, 32'h0040_1ABC, 1'b0,
         32'h0000_8001, 32'h0002_00CF, 32'h0001_0004, 32'h0002_0004,
         2, 32'h0008_0ABC, 1'b0, 5, 0, 0);
    walk("inv_l1", 32'h8000_0010, 32'h0040_1ABC, 1'b0,
         32'h0, 0, 32'h0001_0004, 0,
         1, 32'h0, 1'b1, 3, 0, 0);
    walk("rsv_wr", 32'h8000_0010, 32'h0040_1ABC, 1'b0,
         32'h0000_8005, 0, 32'h0001_0004, 0,
         1, 32'h0, 1'b1, 3, 0, 0);
    walk("st_ro", 32'h8000_0010, 32'h0040_1ABC, 1'b1,
         32'h0000_8001, 32'h0002_0043, 32'h0001_0004, 32'h0002_0004,
         2, 32'h0, 1'b1, 5, 0, 0);
    walk("ld_ro", 32'h8000_0010, 32'h0040_1ABC, 1'b0,
         32'h0000_8001, 32'h0002_0043, 32'h0001_0004, 32'h0002_0004,
         2, 32'h0008_0ABC, 1'b0, 5, 0, 0);
    walk("l0_ptr", 32'h8000_0010, 32'h0040_1ABC, 1'b0,
         32'h0000_8001, 32'h0000_0001, 32'h0001_0004, 32'h0002_0004,
         2, 32'h0, 1'b1, 5, 0, 0);
    walk("super", 32'h8000_0010, 32'h0012_3456, 1'b0,
         32'h2000_00CF, 0, 32'h0001_0000, 0,
         1, sp_pa, sp_f, 3, 0, 0);
    walk("super_mis", 32'h8000_0010, 32'h0012_3456, 1'b0,
         32'h2000_04CF, 0, 32'h0001_0000, 0,
         1, 32'h0, 1'b1, 3, 0, 0);
    walk("bp", 32'h8000_0010, 32'h0040_1ABC, 1'b0,
         32'h0000_8001, 32'h0002_00CF, 32'h0001_0004, 32'h0002_0004,
         2, 32'h0008_0ABC, 1'b0, 8, 3, 2);

    @(negedge clk);
    satp = 32'h8000_0010; req_vaddr = 32'h0040_1ABC;
    req_store = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_l1_mv", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_8001;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("rst_l0_ma", mem_req_addr, 32'h0002_0004);
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("rst_wait_mv", 32'(mem_req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_idle("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0002_00CF;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk_idle("stale");

    walk("after_rst", 32'h8000_0010, 32'h0040_1ABC, 1'b0,
         32'h0000_8001, 32'h0002_00CF, 32'h0001_0004, 32'h0002_0004,
         2, 32'h0008_0ABC, 1'b0, 5, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
